lcd_bus_reader: RTL and testbench

Host-side read engine for the HD44780-compatible character LCD 8-bit parallel bus. It is the read-direction counterpart of the existing write path.
- Runs a single read cycle (RW=1) and returns the byte.
- RS=0 returns the busy flag and address counter.
- RS=1 returns the DDRAM/CGRAM byte at the current address.
- Sits beside the LCD write controller. The top level muxes RS/RW/EN and tristates the FPGA data pins whenever LCD_RW=1.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_phase_timer.sv | 28 ++
 rtl/lcd_bus_reader.sv | 199 +++++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780 bus read engine.
package lcd_pkg;

    // Read-cycle sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } lcdState_t;

    // Status byte layout: bit 7 is the busy flag, bits 6:0 the address counter.
    localparam int         LCD_BF_BIT  = 7;
    localparam logic [7:0] LCD_AC_MASK = 8'h7F;

    // Register select encodings.
    localparam logic LCD_RS_CMD  = 1'b0;
    localparam logic LCD_RS_DATA = 1'b1;

    // Largest of three phase lengths; sizes the shared phase counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter; oTc is high while the count is zero.
// One instance is reused for the SETUP, STROBE and HOLD phases.
module lcd_phase_timer #(
    parameter int W = 5
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         iLoad,
    input  logic [W-1:0] iLoadVal,
    output logic         oTc
);

    logic [W-1:0] cnt;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (iLoad) begin
            cnt <= iLoadVal;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign oTc = (cnt == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: runs one HD44780 read cycle (RW=1) and returns the byte.
// RS=0 reads busy flag + address counter, RS=1 reads DDRAM/CGRAM data.
// Optional macro LCD_BUSY_POLL_EN adds busy-flag polling (iPoll, oTimeout).
//
// Handshake: a request is the rising edge of iStart (iStart & ~iStart_q) seen
// while IDLE; iRS/iPoll are sampled on that edge. oBusy is high from that edge
// through the oDone cycle. oDone is a single-cycle pulse with oDATA valid;
// edges arriving while not IDLE (including the DONE cycle) are dropped, and a
// level held high never retriggers.
module lcd_bus_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 16,
    parameter int HOLD_CYC  = 2
`ifdef LCD_BUSY_POLL_EN
    ,
    parameter int POLL_MAX  = 255
`endif
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    output logic [7:0] oDATA,
    output logic       oDone,
    output logic       oBusy,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
`ifdef LCD_BUSY_POLL_EN
    input  logic       iPoll,
    output logic       oTimeout,
`endif
    output logic [2:0] oState
);

    localparam int CW = $clog2(maxOf3(SETUP_CYC, EN_CYC, HOLD_CYC)) + 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1) begin : gBadPhase
        $error("lcd_bus_reader: SETUP_CYC, EN_CYC and HOLD_CYC must all be >= 1");
    end

`ifdef LCD_BUSY_POLL_EN
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : gBadPoll
        $error("lcd_bus_reader: POLL_MAX must be in 1..255");
    end
    localparam logic [7:0] POLL_MAX_8 = 8'(POLL_MAX);
`endif

    lcdState_t     state, stateNext;
    logic          startQ;
    logic          startEdge;
    logic          timerLoad;
    logic [CW-1:0] timerVal;
    logic          timerTc;
    logic          rsNext, rwNext, enNext, doneNext, busyNext;
    logic [7:0]    dataNext;
`ifdef LCD_BUSY_POLL_EN
    logic          pollMode, pollModeNext;
    logic [7:0]    pollCnt, pollCntNext;
    logic          timeoutNext;
`endif

    assign startEdge = iStart & ~startQ;
    assign oState    = state;

    lcd_phase_timer #(.W(CW)) uTimer (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iLoad    (timerLoad),
        .iLoadVal (timerVal),
        .oTc      (timerTc)
    );

    // State and registered bus/host outputs; reset drops EN and RW at once.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            startQ   <= 1'b0;
            LCD_RS   <= LCD_RS_CMD;
            LCD_RW   <= 1'b0;
            LCD_EN   <= 1'b0;
            oDATA    <= 8'h00;
            oDone    <= 1'b0;
            oBusy    <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            pollMode <= 1'b0;
            pollCnt  <= 8'h00;
            oTimeout <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            startQ   <= iStart;
            LCD_RS   <= rsNext;
            LCD_RW   <= rwNext;
            LCD_EN   <= enNext;
            oDATA    <= dataNext;
            oDone    <= doneNext;
            oBusy    <= busyNext;
`ifdef LCD_BUSY_POLL_EN
            pollMode <= pollModeNext;
            pollCnt  <= pollCntNext;
            oTimeout <= timeoutNext;
`endif
        end
    end

    // Next-state and next-output logic for the read sequence.
    always_comb begin
        stateNext = state;
        timerLoad = 1'b0;
        timerVal  = '0;
        rsNext    = LCD_RS;
        rwNext    = LCD_RW;
        enNext    = LCD_EN;
        dataNext  = oDATA;
        doneNext  = 1'b0;
        busyNext  = oBusy;
`ifdef LCD_BUSY_POLL_EN
        pollModeNext = pollMode;
        pollCntNext  = pollCnt;
        timeoutNext  = oTimeout;
`endif
        unique case (state)
            IDLE: begin
                if (startEdge) begin
`ifdef LCD_BUSY_POLL_EN
                    rsNext       = iPoll ? LCD_RS_CMD : iRS;
                    pollModeNext = iPoll;
                    pollCntNext  = 8'h00;
                    timeoutNext  = 1'b0;
`else
                    rsNext       = iRS;
`endif
                    rwNext    = 1'b1;
                    busyNext  = 1'b1;
                    timerLoad = 1'b1;
                    timerVal  = SETUP_LD;
                    stateNext = SETUP;
                end
            end
            SETUP: begin
                if (timerTc) begin
                    enNext    = 1'b1;
                    timerLoad = 1'b1;
                    timerVal  = EN_LD;
                    stateNext = STROBE;
                end
            end
            STROBE: begin
                if (timerTc) begin
                    // Capture while EN is still high, before the falling edge.
                    dataNext  = LCD_DATA_IN;
                    enNext    = 1'b0;
                    timerLoad = 1'b1;
                    timerVal  = HOLD_LD;
                    stateNext = HOLD;
                end
            end
            HOLD: begin
                if (timerTc) begin
`ifdef LCD_BUSY_POLL_EN
                    if (pollMode && oDATA[LCD_BF_BIT] && (pollCnt < POLL_MAX_8)) begin
                        // LCD still busy: re-read status without releasing RW.
                        pollCntNext = pollCnt + 8'd1;
                        timerLoad   = 1'b1;
                        timerVal    = SETUP_LD;
                        stateNext   = SETUP;
                    end else begin
                        timeoutNext = pollMode & oDATA[LCD_BF_BIT];
                        rwNext      = 1'b0;
                        rsNext      = LCD_RS_CMD;
                        doneNext    = 1'b1;
                        stateNext   = DONE;
                    end
`else
                    rwNext    = 1'b0;
                    rsNext    = LCD_RS_CMD;
                    doneNext  = 1'b1;
                    stateNext = DONE;
`endif
                end
            end
            DONE: begin
                busyNext  = 1'b0;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: directed bench for lcd_bus_reader (default parameters;
// with LCD_BUSY_POLL_EN defined the DUT is built with POLL_MAX=3).
module tb_lcd_bus_reader;

    logic       iCLK;
    logic       iRST_N;
    logic       iStart;
    logic       iRS;
    logic [7:0] oDATA;
    logic       oDone;
    logic       oBusy;
    logic [7:0] LCD_DATA_IN;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [2:0] oState;
`ifdef LCD_BUSY_POLL_EN
    logic       iPoll;
    logic       oTimeout;
`endif

    int nVec;
    int nErr;

    // Per-transaction trace, filled by run_txn (values seen after edge k).
    int   tRwRise, tRwFall, tEnRise, tEnFall, tDone;
    int   nEnRise, nEnFall, nDone;
    logic rsHigh;
    logic busyAtDone, busyAfterDone;
    logic timeoutAtDone;

    // Clock: 10 ns period.
    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

`ifdef LCD_BUSY_POLL_EN
    lcd_bus_reader #(.POLL_MAX(3)) dut (
`else
    lcd_bus_reader dut (
`endif
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iStart      (iStart),
        .iRS         (iRS),
        .oDATA       (oDATA),
        .oDone       (oDone),
        .oBusy       (oBusy),
        .LCD_DATA_IN (LCD_DATA_IN),
        .LCD_RS      (LCD_RS),
        .LCD_RW      (LCD_RW),
        .LCD_EN      (LCD_EN),
`ifdef LCD_BUSY_POLL_EN
        .iPoll       (iPoll),
        .oTimeout    (oTimeout),
`endif
        .oState      (oState)
    );

    // Raise iStart at a falling edge; the next rising edge is edge 0.
    task automatic start_req(input logic rs, input logic [7:0] bus);
        @(negedge iCLK);
        iRS         = rs;
        LCD_DATA_IN = bus;
        iStart      = 1'b1;
    endtask

    // Drop iStart and let the edge detector settle.
    task automatic idle_gap();
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    // Observe maxCyc cycles after start_req, recording event edges.
    // glitchAt: drop iStart after edge glitchAt, raise again after glitchAt+1.
    // After the switchFalls-th EN fall, drive switchVal onto the bus.
    task automatic run_txn(input int maxCyc, input bit dropOnDone, input int glitchAt,
                           input int switchFalls, input logic [7:0] switchVal);
        logic prevEn;
        tRwRise = -1; tRwFall = -1; tEnRise = -1; tEnFall = -1; tDone = -1;
        nEnRise = 0; nEnFall = 0; nDone = 0;
        rsHigh = 1'b0; busyAtDone = 1'b0; busyAfterDone = 1'b1; timeoutAtDone = 1'b0;
        prevEn = 1'b0;
        for (int k = 0; k < maxCyc; k++) begin
            @(negedge iCLK);
            if (LCD_EN && !prevEn) begin
                nEnRise++;
                if (tEnRise < 0) tEnRise = k;
            end
            if (!LCD_EN && prevEn) begin
                nEnFall++;
                if (tEnFall < 0) tEnFall = k;
                if (switchFalls > 0 && nEnFall == switchFalls) LCD_DATA_IN = switchVal;
            end
            if (LCD_RW && tRwRise < 0) tRwRise = k;
            if (!LCD_RW && tRwRise >= 0 && tRwFall < 0) tRwFall = k;
            if (LCD_RS) rsHigh = 1'b1;
            if (tDone >= 0 && k == tDone + 1) busyAfterDone = oBusy;
            if (oDone) begin
                nDone++;
                if (tDone < 0) begin
                    tDone      = k;
                    busyAtDone = oBusy;
`ifdef LCD_BUSY_POLL_EN
                    timeoutAtDone = oTimeout;
`endif
                end
                if (dropOnDone) iStart = 1'b0;
            end
            if (k == glitchAt) iStart = 1'b0;
            if (k == glitchAt + 1) iStart = 1'b1;
            prevEn = LCD_EN;
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0; iStart = 1'b0; iRS = 1'b0; LCD_DATA_IN = 8'h00;
`ifdef LCD_BUSY_POLL_EN
        iPoll = 1'b0;
`endif
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);
        nVec++;
        if ({oDATA, oDone, oBusy, LCD_RS, LCD_RW, LCD_EN} !== 13'h0) begin
            nErr++;
            $display("FAIL reset_outputs: got data=%h done=%b busy=%b rs=%b rw=%b en=%b, want all 0",
                     oDATA, oDone, oBusy, LCD_RS, LCD_RW, LCD_EN);
        end
        nVec++;
        if (oState !== 3'd0) begin
            nErr++; $display("FAIL reset_state: got %0d want 0", oState);
        end
`ifdef LCD_BUSY_POLL_EN
        nVec++;
        if (oTimeout !== 1'b0) begin
            nErr++; $display("FAIL reset_timeout: got %b want 0", oTimeout);
        end
`endif
    endtask

    task automatic test_status_read();
        start_req(1'b0, 8'h2A);
        run_txn(30, 1'b1, -1, 0, 8'h00);
        nVec++;
        if (tRwRise !== 0) begin nErr++; $display("FAIL status_rw_rise: edge %0d want 0", tRwRise); end
        nVec++;
        if (tEnRise !== 2) begin nErr++; $display("FAIL status_en_rise: edge %0d want 2", tEnRise); end
        nVec++;
        if (tEnFall !== 18) begin nErr++; $display("FAIL status_en_fall: edge %0d want 18", tEnFall); end
        nVec++;
        if (tRwFall !== 20) begin nErr++; $display("FAIL status_rw_fall: edge %0d want 20", tRwFall); end
        nVec++;
        if (tDone !== 20) begin nErr++; $display("FAIL status_done_edge: edge %0d want 20", tDone); end
        nVec++;
        if (nDone !== 1) begin nErr++; $display("FAIL status_done_count: got %0d want 1", nDone); end
        nVec++;
        if (oDATA !== 8'h2A) begin nErr++; $display("FAIL status_data: got %h want 2a", oDATA); end
        nVec++;
        if (rsHigh !== 1'b0) begin nErr++; $display("FAIL status_rs: got %b want 0", rsHigh); end
        nVec++;
        if (busyAtDone !== 1'b1 || busyAfterDone !== 1'b0) begin
            nErr++;
            $display("FAIL status_busy: at_done=%b after=%b want 1/0", busyAtDone, busyAfterDone);
        end
        idle_gap();
    endtask

    task automatic test_data_read();
        start_req(1'b1, 8'h41);
        run_txn(30, 1'b1, -1, 0, 8'h00);
        nVec++;
        if (rsHigh !== 1'b1) begin nErr++; $display("FAIL data_rs_high: got %b want 1", rsHigh); end
        nVec++;
        if (LCD_RS !== 1'b0) begin nErr++; $display("FAIL data_rs_after: got %b want 0", LCD_RS); end
        nVec++;
        if (oDATA !== 8'h41) begin nErr++; $display("FAIL data_value: got %h want 41", oDATA); end
        nVec++;
        if (tDone !== 20) begin nErr++; $display("FAIL data_done_edge: edge %0d want 20", tDone); end
        idle_gap();
    endtask

    task automatic test_capture_window();
        start_req(1'b1, 8'h41);
        run_txn(30, 1'b1, -1, 1, 8'hFF);
        nVec++;
        if (oDATA !== 8'h41) begin nErr++; $display("FAIL capture_window: got %h want 41", oDATA); end
        nVec++;
        if (LCD_DATA_IN !== 8'hFF) begin nErr++; $display("FAIL capture_bus_flip: bus %h want ff", LCD_DATA_IN); end
        idle_gap();
    endtask

    task automatic test_back_to_back();
        start_req(1'b0, 8'h13);
        run_txn(60, 1'b1, 3, 0, 8'h00);
        nVec++;
        if (nDone !== 1 || nEnRise !== 1) begin
            nErr++; $display("FAIL b2b_ignored: done=%0d en_pulses=%0d want 1/1", nDone, nEnRise);
        end
        nVec++;
        if (tDone !== 20 || oDATA !== 8'h13) begin
            nErr++; $display("FAIL b2b_result: done_edge=%0d data=%h want 20/13", tDone, oDATA);
        end
        idle_gap();
    endtask

    task automatic test_held_start();
        start_req(1'b0, 8'h7E);
        run_txn(100, 1'b0, -1, 0, 8'h00);
        nVec++;
        if (nDone !== 1 || nEnRise !== 1) begin
            nErr++; $display("FAIL held_start: done=%0d en_pulses=%0d want 1/1", nDone, nEnRise);
        end
        nVec++;
        if (oBusy !== 1'b0) begin nErr++; $display("FAIL held_busy: got %b want 0", oBusy); end
        idle_gap();
    endtask

    task automatic test_edge_in_done();
        start_req(1'b0, 8'h22);
        run_txn(60, 1'b0, 19, 0, 8'h00);
        nVec++;
        if (nDone !== 1 || nEnRise !== 1) begin
            nErr++; $display("FAIL done_cycle_edge: done=%0d en_pulses=%0d want 1/1", nDone, nEnRise);
        end
        idle_gap();
    endtask

    task automatic test_async_reset();
        int doneSeen;
        start_req(1'b0, 8'h33);
        repeat (11) @(negedge iCLK);
        nVec++;
        if (LCD_EN !== 1'b1) begin nErr++; $display("FAIL rst_pre_en: got %b want 1", LCD_EN); end
        iRST_N = 1'b0;
        #1;
        nVec++;
        if (LCD_EN !== 1'b0 || LCD_RW !== 1'b0 || oBusy !== 1'b0) begin
            nErr++; $display("FAIL rst_async: en=%b rw=%b busy=%b want 0/0/0", LCD_EN, LCD_RW, oBusy);
        end
        iStart = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge iCLK);
            if (oDone) doneSeen++;
        end
        iRST_N = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(negedge iCLK);
            if (oDone) doneSeen++;
        end
        nVec++;
        if (doneSeen !== 0) begin nErr++; $display("FAIL rst_no_done: got %0d pulses want 0", doneSeen); end
        start_req(1'b1, 8'h5C);
        run_txn(30, 1'b1, -1, 0, 8'h00);
        nVec++;
        if (tDone !== 20 || oDATA !== 8'h5C) begin
            nErr++; $display("FAIL rst_recover: done_edge=%0d data=%h want 20/5c", tDone, oDATA);
        end
        idle_gap();
    endtask

`ifdef LCD_BUSY_POLL_EN
    task automatic test_poll_clears();
        iPoll = 1'b1;
        start_req(1'b1, 8'h80);
        run_txn(120, 1'b1, -1, 3, 8'h05);
        iPoll = 1'b0;
        nVec++;
        if (nDone !== 1 || nEnRise !== 4) begin
            nErr++; $display("FAIL poll_counts: done=%0d en_pulses=%0d want 1/4", nDone, nEnRise);
        end
        nVec++;
        if (oDATA !== 8'h05 || timeoutAtDone !== 1'b0) begin
            nErr++; $display("FAIL poll_result: data=%h timeout=%b want 05/0", oDATA, timeoutAtDone);
        end
        nVec++;
        if (rsHigh !== 1'b0) begin nErr++; $display("FAIL poll_rs_forced: got %b want 0", rsHigh); end
        nVec++;
        if (tRwFall !== tDone) begin
            nErr++; $display("FAIL poll_rw_held: rw fell at %0d, done at %0d", tRwFall, tDone);
        end
        idle_gap();
    endtask

    task automatic test_poll_timeout();
        iPoll = 1'b1;
        start_req(1'b0, 8'hFF);
        run_txn(120, 1'b1, -1, 0, 8'h00);
        iPoll = 1'b0;
        nVec++;
        if (nDone !== 1 || nEnRise !== 4) begin
            nErr++; $display("FAIL poll_to_counts: done=%0d en_pulses=%0d want 1/4", nDone, nEnRise);
        end
        nVec++;
        if (timeoutAtDone !== 1'b1 || oDATA !== 8'hFF) begin
            nErr++; $display("FAIL poll_to_flag: timeout=%b data=%h want 1/ff", timeoutAtDone, oDATA);
        end
        idle_gap();
        start_req(1'b0, 8'h01);
        run_txn(30, 1'b1, -1, 0, 8'h00);
        nVec++;
        if (timeoutAtDone !== 1'b0 || nEnRise !== 1) begin
            nErr++; $display("FAIL poll_to_clear: timeout=%b en_pulses=%0d want 0/1", timeoutAtDone, nEnRise);
        end
        idle_gap();
    endtask
`endif

    initial begin
        nVec = 0;
        nErr = 0;
        test_reset();
        test_status_read();
        test_data_read();
        test_capture_window();
        test_back_to_back();
        test_held_start();
        test_edge_in_done();
        test_async_reset();
`ifdef LCD_BUSY_POLL_EN
        test_poll_clears();
        test_poll_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
